// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-SRAM load/store front end:
// RISC-V size codes, FSM states and byte-enable patterns.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational access checker: size/alignment/range error, store byte
// enables and sign/zero extension of raw SRAM read data.
module mem_align
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic        err_o,
    output logic [31:0] ldata_o
);

    logic       range_err_s;
    logic       align_err_s;
    logic       f3_err_s;
    logic [3:0] size_be_s;

    // Decode size code into enables, error causes and extended load data
    always_comb begin
        range_err_s = ((addr_i >> ADDR_W) != 32'd0);
        align_err_s = 1'b0;
        f3_err_s    = 1'b0;
        size_be_s   = 4'b0000;
        ldata_o     = 32'd0;
        case (funct3_i)
            F3_B: begin
                size_be_s = BE_B;
                ldata_o   = {{24{rdata_i[7]}}, rdata_i[7:0]};
            end
            F3_BU: begin
                f3_err_s = we_i;
                ldata_o  = {24'd0, rdata_i[7:0]};
            end
            F3_H: begin
                align_err_s = addr_i[0];
                size_be_s   = BE_H;
                ldata_o     = {{16{rdata_i[15]}}, rdata_i[15:0]};
            end
            F3_HU: begin
                align_err_s = addr_i[0];
                f3_err_s    = we_i;
                ldata_o     = {16'd0, rdata_i[15:0]};
            end
            F3_W: begin
                align_err_s = (addr_i[1:0] != 2'b00);
                size_be_s   = BE_W;
                ldata_o     = rdata_i;
            end
            default: begin
                f3_err_s = 1'b1;
            end
        endcase

        err_o = range_err_s | align_err_s | f3_err_s;
        if (we_i && !err_o) begin
            be_o = size_be_s;
        end else begin
            be_o = 4'b0000;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store front end for the data SRAM:
// IDLE accepts a request, ACCESS drives the SRAM for one cycle, RESP holds the reply.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [3:0]        mem_w_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    state_e              state_q, state_d;
    logic                we_q;
    logic [2:0]          funct3_q;
    logic                err_q;
    logic [ADDR_W-1:0]   mem_address_q;
    logic [31:0]         mem_write_data_q;
    logic [3:0]          mem_w_en_q;
    logic                rsp_valid_q;
    logic [31:0]         rsp_rdata_q;
    logic                rsp_err_q;

    logic                accept_s;
    logic [2:0]          al_funct3_s;
    logic [31:0]         al_addr_s;
    logic                al_we_s;
    logic [3:0]          al_be_s;
    logic                al_err_s;
    logic [31:0]         al_ldata_s;

    assign req_ready      = (state_q == IDLE);
    assign accept_s       = req_valid && (state_q == IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_err        = rsp_err_q;
    assign mem_w_en       = mem_w_en_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;

    // The checker sees the live request in IDLE and the latched one afterwards
    always_comb begin
        if (state_q == IDLE) begin
            al_funct3_s = req_funct3;
            al_addr_s   = req_addr;
            al_we_s     = req_we;
        end else begin
            al_funct3_s = funct3_q;
            al_addr_s   = {{(32-ADDR_W){1'b0}}, mem_address_q};
            al_we_s     = we_q;
        end
    end

    mem_align #(
        .ADDR_W (ADDR_W)
    ) u_align (
        .funct3_i (al_funct3_s),
        .addr_i   (al_addr_s),
        .we_i     (al_we_s),
        .rdata_i  (mem_read_data),
        .be_o     (al_be_s),
        .err_o    (al_err_s),
        .ldata_o  (al_ldata_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch, one-cycle SRAM write strobe and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q             <= 1'b0;
            funct3_q         <= 3'b000;
            err_q            <= 1'b0;
            mem_address_q    <= {ADDR_W{1'b0}};
            mem_write_data_q <= 32'd0;
            mem_w_en_q       <= 4'b0000;
            rsp_valid_q      <= 1'b0;
            rsp_rdata_q      <= 32'd0;
            rsp_err_q        <= 1'b0;
        end else begin
            mem_w_en_q <= 4'b0000;
            if (accept_s) begin
                we_q             <= req_we;
                funct3_q         <= req_funct3;
                err_q            <= al_err_s;
                mem_address_q    <= req_addr[ADDR_W-1:0];
                mem_write_data_q <= req_wdata;
                mem_w_en_q       <= al_be_s;
            end else if (state_q == ACCESS) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= err_q;
                // Stores and errored accesses reply with zero data
                if (we_q || err_q) begin
                    rsp_rdata_q <= 32'd0;
                end else begin
                    rsp_rdata_q <= al_ldata_s;
                end
            end else if ((state_q == RESP) && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end else begin
                rsp_valid_q <= rsp_valid_q;
            end
        end
    end

endmodule
